// File: rtl/int_wb_port_arbiter.sv
// Integer regfile write-port arbiter: pipeline WB has absolute priority, divider and AMO
// completions share the leftover slots round-robin, with a divide pending-rd scoreboard.
module int_wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wb_valid,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_div_valid,
    input  logic [4:0]      i_div_rd,
    input  logic [XLEN-1:0] i_div_data,
    output logic            o_div_ready,
    input  logic            i_amo_valid,
    input  logic [4:0]      i_amo_rd,
    input  logic [XLEN-1:0] i_amo_data,
    output logic            o_amo_ready,
    input  logic            i_div_issue,
    input  logic [4:0]      i_div_issue_rd,
    input  logic            i_flush,
    output logic            o_rf_we,
    output logic [4:0]      o_rf_rd,
    output logic [XLEN-1:0] o_rf_wdata,
    output logic [31:0]     o_pending_mask,
    output logic            o_stall_req
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        SIDE_DIV = 1'b0,
        SIDE_AMO = 1'b1
    } side_e;

    side_e            r_rr_ptr;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [31:0]      r_pending;
    logic             r_rf_we;
    logic [4:0]       r_rf_rd;
    logic [XLEN-1:0]  r_rf_wdata;

    logic             w_div_ready;
    logic             w_amo_ready;
    logic             w_side_grant;
    logic             w_grant;
    logic [4:0]       w_win_rd;
    logic [XLEN-1:0]  w_win_data;
    logic [31:0]      w_set_mask;
    logic [31:0]      w_clr_mask;
    logic [31:0]      w_pending_nxt;
    logic             w_starve_inc;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it
    // unassigned; a missing default on any branch infers a latch.
    always_comb begin
        w_win_rd   = i_wb_rd;
        w_win_data = i_wb_data;

        // Pointer only matters when both side writers compete for a free port.
        w_div_ready  = ~i_wb_valid & i_div_valid & (~i_amo_valid | (r_rr_ptr == SIDE_DIV));
        w_amo_ready  = ~i_wb_valid & i_amo_valid & (~i_div_valid | (r_rr_ptr == SIDE_AMO));
        w_side_grant = w_div_ready | w_amo_ready;
        w_grant      = i_wb_valid | w_side_grant;

        if (w_div_ready) begin
            w_win_rd   = i_div_rd;
            w_win_data = i_div_data;
        end else if (w_amo_ready) begin
            w_win_rd   = i_amo_rd;
            w_win_data = i_amo_data;
        end

        // Set is OR-ed in after the clear, so a same-cycle reissue of rd keeps it pending.
        w_set_mask    = i_div_issue ? (32'd1 << i_div_issue_rd) : 32'd0;
        w_clr_mask    = w_div_ready ? (32'd1 << i_div_rd) : 32'd0;
        w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;

        w_starve_inc  = (i_div_valid | i_amo_valid) & ~w_side_grant & (r_starve_cnt != CNT_MAX);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr     <= SIDE_DIV;
            r_starve_cnt <= '0;
            r_pending    <= '0;
            r_rf_we      <= 1'b0;
            r_rf_rd      <= '0;
            r_rf_wdata   <= '0;
        end else begin
            r_rf_we <= w_grant & (w_win_rd != 5'd0);
            if (w_grant) begin
                r_rf_rd    <= w_win_rd;
                r_rf_wdata <= w_win_data;
            end

            // Flush resets bookkeeping only; a same-cycle handshake above still lands.
            if (i_flush) begin
                r_rr_ptr     <= SIDE_DIV;
                r_starve_cnt <= '0;
                r_pending    <= '0;
            end else begin
                r_pending <= w_pending_nxt;
                if (w_side_grant) begin
                    r_starve_cnt <= '0;
                end else if (w_starve_inc) begin
                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                end
                if (w_div_ready) begin
                    r_rr_ptr <= SIDE_AMO;
                end else if (w_amo_ready) begin
                    r_rr_ptr <= SIDE_DIV;
                end
            end
        end
    end

    assign o_div_ready    = w_div_ready;
    assign o_amo_ready    = w_amo_ready;
    assign o_rf_we        = r_rf_we;
    assign o_rf_rd        = r_rf_rd;
    assign o_rf_wdata     = r_rf_wdata;
    assign o_pending_mask = r_pending;
    assign o_stall_req    = (r_starve_cnt == CNT_MAX);

endmodule

// File: tb/tb_int_wb_port_arbiter.sv
// Directed bench for int_wb_port_arbiter: expected regfile writes go into a queue that a
// negedge monitor drains; handshake, scoreboard and stall outputs are checked inline.
module tb_int_wb_port_arbiter;

    localparam int XLEN = 32;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_wb_valid, i_div_valid, i_amo_valid, i_div_issue, i_flush;
    logic [4:0]      i_wb_rd, i_div_rd, i_amo_rd, i_div_issue_rd;
    logic [XLEN-1:0] i_wb_data, i_div_data, i_amo_data;
    logic            o_div_ready, o_amo_ready, o_rf_we, o_stall_req;
    logic [4:0]      o_rf_rd;
    logic [XLEN-1:0] o_rf_wdata;
    logic [31:0]     o_pending_mask;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t exp_q[$];

    int_wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_wb_valid     (i_wb_valid),
        .i_wb_rd        (i_wb_rd),
        .i_wb_data      (i_wb_data),
        .i_div_valid    (i_div_valid),
        .i_div_rd       (i_div_rd),
        .i_div_data     (i_div_data),
        .o_div_ready    (o_div_ready),
        .i_amo_valid    (i_amo_valid),
        .i_amo_rd       (i_amo_rd),
        .i_amo_data     (i_amo_data),
        .o_amo_ready    (o_amo_ready),
        .i_div_issue    (i_div_issue),
        .i_div_issue_rd (i_div_issue_rd),
        .i_flush        (i_flush),
        .o_rf_we        (o_rf_we),
        .o_rf_rd        (o_rf_rd),
        .o_rf_wdata     (o_rf_wdata),
        .o_pending_mask (o_pending_mask),
        .o_stall_req    (o_stall_req)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [XLEN-1:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Monitor: every registered write must match the oldest expected write.
    always @(negedge i_clk) begin
        if (i_rst_n && o_rf_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_rd", {59'd0, o_rf_rd}, 64'hFFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_rd",   {59'd0, o_rf_rd}, {59'd0, w.rd});
                check("write_data", {32'd0, o_rf_wdata}, {32'd0, w.data});
            end
        end
    end

    initial begin
        i_rst_n = 1'b0;
        {i_wb_valid, i_div_valid, i_amo_valid, i_div_issue, i_flush} = '0;
        {i_wb_rd, i_div_rd, i_amo_rd, i_div_issue_rd} = '0;
        {i_wb_data, i_div_data, i_amo_data} = '0;

        @(negedge i_clk);
        check("rst_we",    {63'd0, o_rf_we}, 64'd0);
        check("rst_rd",    {59'd0, o_rf_rd}, 64'd0);
        check("rst_wdata", {32'd0, o_rf_wdata}, 64'd0);
        check("rst_mask",  {32'd0, o_pending_mask}, 64'd0);
        check("rst_stall", {63'd0, o_stall_req}, 64'd0);
        tick();
        i_rst_n = 1'b1;

        // 1: WB beats a waiting divider; divider lands once WB drops.
        i_wb_valid = 1; i_wb_rd = 5; i_wb_data = 32'h11;
        i_div_valid = 1; i_div_rd = 6; i_div_data = 32'h66;
        push(5, 32'h11);
        @(negedge i_clk);
        check("t1_div_blocked", {63'd0, o_div_ready}, 64'd0);
        tick();
        i_wb_valid = 0;
        push(6, 32'h66);
        @(negedge i_clk);
        check("t1_div_ready", {63'd0, o_div_ready}, 64'd1);
        tick();
        i_div_valid = 0;

        // Flush with nothing else active returns the pointer to DIV.
        i_flush = 1;
        tick();
        i_flush = 0;

        // 2: both side writers held -> DIV, AMO, DIV, AMO.
        i_div_valid = 1; i_div_rd = 8; i_div_data = 32'h80;
        i_amo_valid = 1; i_amo_rd = 9; i_amo_data = 32'h90;
        @(negedge i_clk);
        check("t2_c1_div", {62'd0, o_div_ready, o_amo_ready}, 64'b10);
        push(8, 32'h80);
        tick();
        i_div_rd = 10; i_div_data = 32'hA0;
        @(negedge i_clk);
        check("t2_c2_amo", {62'd0, o_div_ready, o_amo_ready}, 64'b01);
        push(9, 32'h90);
        tick();
        i_amo_rd = 11; i_amo_data = 32'hB0;
        @(negedge i_clk);
        check("t2_c3_div", {62'd0, o_div_ready, o_amo_ready}, 64'b10);
        push(10, 32'hA0);
        tick();
        i_div_valid = 0;
        @(negedge i_clk);
        check("t2_c4_amo", {62'd0, o_div_ready, o_amo_ready}, 64'b01);
        push(11, 32'hB0);
        tick();
        i_amo_valid = 0;

        // 3: AMO starved by 4 WB cycles -> stall request, then grant clears it.
        i_amo_valid = 1; i_amo_rd = 12; i_amo_data = 32'hC0;
        for (int c = 0; c < 4; c++) begin
            i_wb_valid = 1; i_wb_rd = 5'(c + 1); i_wb_data = 32'hA0 + 32'(c);
            push(5'(c + 1), 32'hA0 + 32'(c));
            @(negedge i_clk);
            check("t3_no_stall_yet", {63'd0, o_stall_req}, 64'd0);
            tick();
        end
        i_wb_valid = 0;
        @(negedge i_clk);
        check("t3_stall_req",  {63'd0, o_stall_req}, 64'd1);
        check("t3_amo_ready",  {63'd0, o_amo_ready}, 64'd1);
        push(12, 32'hC0);
        tick();
        i_amo_valid = 0;
        @(negedge i_clk);
        check("t3_stall_drop", {63'd0, o_stall_req}, 64'd0);

        // 4: pending scoreboard set / set-beats-clear / clear.
        i_div_issue = 1; i_div_issue_rd = 7;
        tick();
        i_div_issue = 0;
        @(negedge i_clk);
        check("t4_mask_set", {32'd0, o_pending_mask}, 64'h80);
        i_div_valid = 1; i_div_rd = 7; i_div_data = 32'h77;
        i_div_issue = 1; i_div_issue_rd = 7;
        push(7, 32'h77);
        tick();
        i_div_issue = 0; i_div_data = 32'h78;
        @(negedge i_clk);
        check("t4_set_wins", {32'd0, o_pending_mask}, 64'h80);
        push(7, 32'h78);
        tick();
        i_div_valid = 0;
        @(negedge i_clk);
        check("t4_mask_clr", {32'd0, o_pending_mask}, 64'h0);

        // 5: rd=0 handshake completes without a write; x0 never pending.
        i_amo_valid = 1; i_amo_rd = 0; i_amo_data = 32'hDEAD;
        @(negedge i_clk);
        check("t5_amo_ready", {63'd0, o_amo_ready}, 64'd1);
        tick();
        i_amo_valid = 0;
        i_div_issue = 1; i_div_issue_rd = 0;
        @(negedge i_clk);
        check("t5_we_x0",    {63'd0, o_rf_we}, 64'd0);
        check("t5_rd_x0",    {59'd0, o_rf_rd}, 64'd0);
        check("t5_data_x0",  {32'd0, o_rf_wdata}, 64'hDEAD);
        tick();
        i_div_issue = 0;
        @(negedge i_clk);
        check("t5_mask_x0",  {32'd0, o_pending_mask}, 64'h0);
        check("t5_hold_rd",  {59'd0, o_rf_rd}, 64'd0);
        check("t5_hold_data",{32'd0, o_rf_wdata}, 64'hDEAD);

        // 6: build mask 0x1F0 and a stall request, then flush.
        for (int c = 0; c < 5; c++) begin
            i_div_issue = 1; i_div_issue_rd = 5'(4 + c);
            if (c < 4) begin
                i_wb_valid = 1; i_wb_rd = 5'(16 + c); i_wb_data = 32'hB0 + 32'(c);
                i_amo_valid = 1; i_amo_rd = 15; i_amo_data = 32'hF5;
                push(5'(16 + c), 32'hB0 + 32'(c));
            end else begin
                i_wb_valid = 0; i_amo_valid = 0;
            end
            tick();
        end
        i_div_issue = 0;
        i_flush = 1;
        i_div_valid = 1; i_div_rd = 14; i_div_data = 32'hE4;
        @(negedge i_clk);
        check("t6_mask_pre",  {32'd0, o_pending_mask}, 64'h1F0);
        check("t6_stall_pre", {63'd0, o_stall_req}, 64'd1);
        check("t6_div_ready_flush", {63'd0, o_div_ready}, 64'd1);
        push(14, 32'hE4);
        tick();
        i_flush = 0;
        i_div_rd = 20; i_div_data = 32'h20;
        i_amo_valid = 1; i_amo_rd = 21; i_amo_data = 32'h21;
        @(negedge i_clk);
        check("t6_mask_flushed",  {32'd0, o_pending_mask}, 64'h0);
        check("t6_stall_flushed", {63'd0, o_stall_req}, 64'd0);
        check("t6_ptr_div",       {62'd0, o_div_ready, o_amo_ready}, 64'b10);
        push(20, 32'h20);
        tick();
        i_div_valid = 0;
        @(negedge i_clk);
        check("t6_amo_next", {63'd0, o_amo_ready}, 64'd1);
        push(21, 32'h21);
        tick();
        i_amo_valid = 0;

        // Reset while a write is on the port and a divider handshake is in progress.
        i_wb_valid = 1; i_wb_rd = 23; i_wb_data = 32'h23;
        push(23, 32'h23);
        tick();
        i_wb_valid = 0;
        i_div_valid = 1; i_div_rd = 22; i_div_data = 32'h22;
        @(negedge i_clk);
        check("t6_div_ready_pre_rst", {63'd0, o_div_ready}, 64'd1);
        #1;
        i_rst_n = 1'b0;
        i_div_valid = 0;
        #1;
        check("t6_rst_we_now",    {63'd0, o_rf_we}, 64'd0);
        check("t6_rst_rd_now",    {59'd0, o_rf_rd}, 64'd0);
        check("t6_rst_wdata_now", {32'd0, o_rf_wdata}, 64'd0);
        @(negedge i_clk);
        check("t6_rst_lost_xfer", {63'd0, o_rf_we}, 64'd0);
        tick();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("write_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
